// File: rtl/hazard_unit_if.sv
// Pipeline hazard interface: register specifiers and stage controls in,
// stall/flush/forwarding and mult/div status out.
interface hazard_unit_if;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic [4:0]  rsE;
    logic [4:0]  rtE;
    logic [4:0]  writeregE;
    logic [4:0]  writeregM;
    logic [4:0]  writeregW;

    logic        branchD;
    logic        MemtoRegE;
    logic        RegWriteE;
    logic        MemtoRegM;
    logic        RegWriteM;
    logic        RegWriteW;

    logic        mdStartE;
    logic        mdIsDivE;
    logic        useHiLoD;

    logic        stallF;
    logic        stallD;
    logic        flushE;
    logic        forwardAD;
    logic        forwardBD;
    logic [1:0]  forwardAE;
    logic [1:0]  forwardBE;
    logic        mdBusy;
    logic        mdDone;
    logic [31:0] stallCount;
    logic [31:0] flushCount;

    // Pipeline side: drives stage state, consumes hazard decisions.
    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        output branchD, MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW,
        output mdStartE, mdIsDivE, useHiLoD,
        input  stallF, stallD, flushE, forwardAD, forwardBD,
        input  forwardAE, forwardBE, mdBusy, mdDone, stallCount, flushCount
    );

    // Hazard unit side.
    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        input  branchD, MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW,
        input  mdStartE, mdIsDivE, useHiLoD,
        output stallF, stallD, flushE, forwardAD, forwardBD,
        output forwardAE, forwardBE, mdBusy, mdDone, stallCount, flushCount
    );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: forwarding, load/branch/mult-div stalls,
// mult/div latency sequencer. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_unit #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned FWD_W  = 2;
    localparam int unsigned PERF_W = 32;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
    localparam logic [FWD_W-1:0] FWD_W_ = 2'b01;
    localparam logic [FWD_W-1:0] FWD_M  = 2'b10;

    // Encoding lets mdBusy/mdDone come straight off state flops.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_e;

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] md_load;

    logic             lwstall;
    logic             branchstall;
    logic             mdstall;
    logic             stall_any;
    logic [FWD_W-1:0] fwd_ae;
    logic [FWD_W-1:0] fwd_be;
    logic             fwd_ad;
    logic             fwd_bd;

    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] wr_m,
        input logic       we_m,
        input logic [4:0] wr_w,
        input logic       we_w
    );
        logic [FWD_W-1:0] sel;
        sel = FWD_RF;
        if ((src != 5'd0) && (src == wr_m) && we_m) begin
            sel = FWD_M;
        end else if ((src != 5'd0) && (src == wr_w) && we_w) begin
            sel = FWD_W_;
        end
        return sel;
    endfunction

    // Forwarding selects and stall sources.
    always_comb begin
        fwd_ae = fwd_sel(hz.rsE, hz.writeregM, hz.RegWriteM, hz.writeregW, hz.RegWriteW);
        fwd_be = fwd_sel(hz.rtE, hz.writeregM, hz.RegWriteM, hz.writeregW, hz.RegWriteW);
        fwd_ad = (hz.rsD != 5'd0) && (hz.rsD == hz.writeregM) && hz.RegWriteM;
        fwd_bd = (hz.rtD != 5'd0) && (hz.rtD == hz.writeregM) && hz.RegWriteM;

        lwstall     = hz.MemtoRegE && ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));
        branchstall = hz.branchD &&
                      ((hz.RegWriteE && ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
                       (hz.MemtoRegM && ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));
        mdstall     = hz.useHiLoD && ((state_q == BUSY) || hz.mdStartE);

        stall_any   = !rst && (lwstall || branchstall || mdstall);
    end

    // Outputs are forced quiet while reset is held, whatever the inputs say.
    assign hz.stallF    = stall_any;
    assign hz.stallD    = stall_any;
    assign hz.flushE    = stall_any;
    assign hz.forwardAD = !rst && fwd_ad;
    assign hz.forwardBD = !rst && fwd_bd;
    assign hz.forwardAE = rst ? FWD_RF : fwd_ae;
    assign hz.forwardBE = rst ? FWD_RF : fwd_be;
    assign hz.mdBusy    = state_q[0];
    assign hz.mdDone    = state_q[1];

    assign md_load = hz.mdIsDivE ? DIV_LOAD : MUL_LOAD;

    // Mult/div sequencer: BUSY lasts latency-1 cycles, DONE one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (hz.mdStartE) begin
                        state_q <= BUSY;
                        cnt_q   <= md_load;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    // Saturating event counters; stallD and flushE share one source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_any && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (stall_any && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign hz.stallCount = stall_cnt_q;
    assign hz.flushCount = flush_cnt_q;
`else
    assign hz.stallCount = PERF_W'(0);
    assign hz.flushCount = PERF_W'(0);
`endif

endmodule
